// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, in-order imem requests and a small allocation queue.
// Optional macro FETCH_MISALIGN_EXC_EN turns misaligned redirects into a halting exception entry.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        sync_rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      pc_reg;
  logic [PTR_W-1:0] alloc_ptr;
  logic [PTR_W-1:0] fill_ptr;
  logic [PTR_W-1:0] head_ptr;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] pend_reg;
  logic [CNT_W-1:0] drop_reg;
  logic             halted_reg;

  logic [31:0] q_pc     [DEPTH];
  logic [31:0] q_instr  [DEPTH];
  logic        q_filled [DEPTH];

  logic             req_hs;
  logic             rsp_fill;
  logic             pop;
  logic [CNT_W-1:0] drop_redirect;
  logic [DEPTH-1:0] alloc_sel;
  logic [DEPTH-1:0] fill_sel;

  // Credits cover both live entries and stale requests still out in memory.
  assign imem_req_valid = !halted_reg &&
                          (({1'b0, count_reg} + {1'b0, drop_reg}) < (CNT_W+1)'(DEPTH));
  assign imem_req_addr  = pc_reg;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign rsp_fill       = imem_rsp_valid && (drop_reg == '0);

  assign out_valid = (count_reg != '0) && q_filled[head_ptr];
  assign out_pc    = q_pc[head_ptr];
  assign out_instr = q_instr[head_ptr];
  assign pop       = out_valid && out_ready;

  // A response in the redirect cycle is stale whichever counter it would have decremented.
  assign drop_redirect = drop_reg + pend_reg + CNT_W'(req_hs) - CNT_W'(imem_rsp_valid);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
    assign alloc_sel[gi] = req_hs && (alloc_ptr == PTR_W'(gi));
    assign fill_sel[gi]  = rsp_fill && (fill_ptr == PTR_W'(gi));
  end

`ifdef FETCH_MISALIGN_EXC_EN
  logic q_exc [DEPTH];
  logic misalign;

  assign misalign = redirect_pc[1:0] != 2'b00;
  assign out_exc  = q_exc[head_ptr];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (sync_rst) begin
        q_exc[i] <= 1'b0;
      end else if (redirect) begin
        if (misalign && i == 0) q_exc[i] <= 1'b1;
      end else if (alloc_sel[i]) begin
        q_exc[i] <= 1'b0;
      end
    end
  end
`else
  assign out_exc = 1'b0;
`endif

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (sync_rst) begin
        q_pc[i]     <= '0;
        q_instr[i]  <= '0;
        q_filled[i] <= 1'b0;
      end else if (redirect) begin
`ifdef FETCH_MISALIGN_EXC_EN
        if (misalign && i == 0) begin
          q_pc[i]     <= redirect_pc;
          q_instr[i]  <= 32'h0000_0013;
          q_filled[i] <= 1'b1;
        end
`endif
      end else begin
        if (alloc_sel[i]) begin
          q_pc[i]     <= pc_reg;
          q_filled[i] <= 1'b0;
        end
        if (fill_sel[i]) begin
          q_instr[i]  <= imem_rsp_data;
          q_filled[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      pc_reg     <= RESET_PC;
      alloc_ptr  <= '0;
      fill_ptr   <= '0;
      head_ptr   <= '0;
      count_reg  <= '0;
      pend_reg   <= '0;
      drop_reg   <= '0;
      halted_reg <= 1'b0;
    end else if (redirect) begin
      pc_reg     <= redirect_pc & ~32'h3;
      alloc_ptr  <= '0;
      fill_ptr   <= '0;
      head_ptr   <= '0;
      count_reg  <= '0;
      pend_reg   <= '0;
      drop_reg   <= drop_redirect;
      halted_reg <= 1'b0;
`ifdef FETCH_MISALIGN_EXC_EN
      // The exception entry is born filled, so both alloc and fill move past it.
      if (misalign) begin
        alloc_ptr  <= PTR_W'(1);
        fill_ptr   <= PTR_W'(1);
        count_reg  <= CNT_W'(1);
        halted_reg <= 1'b1;
      end
`endif
    end else begin
      if (req_hs) begin
        alloc_ptr <= alloc_ptr + PTR_W'(1);
        pc_reg    <= pc_reg + 32'd4;
      end
      if (imem_rsp_valid) begin
        if (drop_reg != '0) drop_reg <= drop_reg - CNT_W'(1);
        else                fill_ptr <= fill_ptr + PTR_W'(1);
      end
      if (pop) head_ptr <= head_ptr + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(req_hs) - CNT_W'(pop);
      pend_reg  <= pend_reg + CNT_W'(req_hs) - CNT_W'(rsp_fill);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: epoch-tagged memory model plus an expected-output queue.
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        sync_rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .sync_rst(sync_rst),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_exc(out_exc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Memory holds every accepted request (stale or live) with the epoch it was issued in.
  logic [31:0] mem_addr_q[$];
  int          mem_ep_q[$];
  // Instructions the fetch unit is expected to present, in order.
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_ins_q[$];
  logic        exp_exc_q[$];

  int          cur_ep = 0;
  logic [31:0] exp_req_pc;
  bit          m_halted;
  int          req_pct, rsp_pct, out_pct;
  int          cyc, first_req_cyc, first_out_cyc, n_req, n_out;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
  endfunction

  task automatic model_clear();
    mem_addr_q.delete(); mem_ep_q.delete();
    exp_pc_q.delete(); exp_ins_q.delete(); exp_exc_q.delete();
    cur_ep++;
    exp_req_pc = RESET_PC;
    m_halted = 1'b0;
    cyc = 0; first_req_cyc = -1; first_out_cyc = -1; n_req = 0; n_out = 0;
  endtask

  task automatic do_reset();
    sync_rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sync_rst = 1'b0;
    model_clear();
  endtask

  // One clock: drive at the falling edge, score against the model, then cross the rising edge.
  task automatic step(input bit rdir, input logic [31:0] rpc);
    bit exp_rv, exp_ov;
    imem_req_ready = ($urandom_range(99) < req_pct);
    imem_rsp_valid = (mem_addr_q.size() > 0) && ($urandom_range(99) < rsp_pct);
    imem_rsp_data  = imem_rsp_valid ? memf(mem_addr_q[0]) : $urandom;
    out_ready      = ($urandom_range(99) < out_pct);
    redirect       = rdir;
    redirect_pc    = rdir ? rpc : $urandom;
    #1;
    exp_rv = !m_halted && (mem_addr_q.size() + exp_pc_q.size() < DEPTH);
    exp_ov = exp_pc_q.size() != 0;
    n_checks++;
    if (imem_req_valid !== exp_rv)
      $display("FAIL req_valid cyc=%0d got=%0b exp=%0b", cyc, imem_req_valid, exp_rv);
    else n_pass++;
    if (imem_req_valid && exp_rv) begin
      n_checks++;
      if (imem_req_addr !== exp_req_pc)
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_req_pc);
      else n_pass++;
    end
    n_checks++;
    if (out_valid !== exp_ov)
      $display("FAIL out_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, exp_ov);
    else n_pass++;
    if (out_valid && exp_ov) begin
      n_checks++;
      if ({out_pc, out_instr, out_exc} !== {exp_pc_q[0], exp_ins_q[0], exp_exc_q[0]})
        $display("FAIL out_data cyc=%0d got=%h/%h/%0b exp=%h/%h/%0b", cyc, out_pc, out_instr,
                 out_exc, exp_pc_q[0], exp_ins_q[0], exp_exc_q[0]);
      else n_pass++;
      if (first_out_cyc < 0) first_out_cyc = cyc;
      if (out_ready) begin
        void'(exp_pc_q.pop_front()); void'(exp_ins_q.pop_front()); void'(exp_exc_q.pop_front());
        n_out++;
      end
    end
    if (imem_rsp_valid) begin
      if (!rdir && mem_ep_q[0] == cur_ep) begin
        exp_pc_q.push_back(mem_addr_q[0]);
        exp_ins_q.push_back(memf(mem_addr_q[0]));
        exp_exc_q.push_back(1'b0);
      end
      void'(mem_addr_q.pop_front()); void'(mem_ep_q.pop_front());
    end
    if (imem_req_valid && imem_req_ready) begin
      mem_addr_q.push_back(exp_req_pc);
      mem_ep_q.push_back(cur_ep);
      exp_req_pc += 32'd4;
      if (first_req_cyc < 0) first_req_cyc = cyc;
      n_req++;
    end
    if (rdir) begin
      cur_ep++;
      exp_pc_q.delete(); exp_ins_q.delete(); exp_exc_q.delete();
      exp_req_pc = rpc & ~32'h3;
      m_halted = 1'b0;
`ifdef FETCH_MISALIGN_EXC_EN
      if (rpc[1:0] != 2'b00) begin
        exp_pc_q.push_back(rpc); exp_ins_q.push_back(32'h0000_0013); exp_exc_q.push_back(1'b1);
        m_halted = 1'b1;
      end
`endif
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_out(input string name);
    int k = 0;
    while (!out_valid && k < 40) begin step(1'b0, '0); k++; end
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL %s_timeout got out_valid=%0b exp=1", name, out_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({out_valid, out_pc, out_instr, out_exc} !== 66'h0)
      $display("FAIL reset_out got=%0b/%h/%h/%0b exp=0/0/0/0", out_valid, out_pc, out_instr, out_exc);
    else n_pass++;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC)
      $display("FAIL reset_req got=%0b/%h exp=1/%h", imem_req_valid, imem_req_addr, RESET_PC);
    else n_pass++;
    $display("test_reset done: checks=%0d", n_checks);
  endtask

  task automatic test_stream();
    do_reset();
    req_pct = 100; rsp_pct = 100; out_pct = 100;
    repeat (30) step(1'b0, '0);
    n_checks++;
    if (first_out_cyc - first_req_cyc !== 2)
      $display("FAIL stream_latency got=%0d exp=2", first_out_cyc - first_req_cyc);
    else n_pass++;
    n_checks++;
    if (n_out < 15) $display("FAIL stream_count got=%0d exp>=15", n_out);
    else n_pass++;
    $display("test_stream done: reqs=%0d outs=%0d", n_req, n_out);
  endtask

  task automatic test_backpressure();
    do_reset();
    req_pct = 100; rsp_pct = 100; out_pct = 0;
    repeat (8) step(1'b0, '0);
    n_checks++;
    if (n_req !== DEPTH || imem_req_valid !== 1'b0)
      $display("FAIL bp_stall got reqs=%0d valid=%0b exp reqs=%0d valid=0", n_req, imem_req_valid, DEPTH);
    else n_pass++;
    out_pct = 100;
    step(1'b0, '0);
    n_checks++;
    if (imem_req_valid !== 1'b1) $display("FAIL bp_resume got=%0b exp=1", imem_req_valid);
    else n_pass++;
    repeat (10) step(1'b0, '0);
    $display("test_backpressure done: reqs=%0d outs=%0d", n_req, n_out);
  endtask

  task automatic test_redirect_drop();
    do_reset();
    req_pct = 100; rsp_pct = 0; out_pct = 100;
    repeat (2) step(1'b0, '0);
    n_checks++;
    if (n_req !== 2) $display("FAIL drop_inflight got=%0d exp=2", n_req);
    else n_pass++;
    step(1'b1, 32'h0000_0100);
    rsp_pct = 100;
    wait_out("drop");
    n_checks++;
    if (out_pc !== 32'h0000_0100) $display("FAIL drop_first_pc got=%h exp=00000100", out_pc);
    else n_pass++;
    repeat (10) step(1'b0, '0);
    $display("test_redirect_drop done: outs=%0d", n_out);
  endtask

  task automatic test_collision();
    do_reset();
    req_pct = 100; rsp_pct = 100; out_pct = 100;
    step(1'b0, '0);
    n_checks++;
    if (imem_req_valid !== 1'b1 || mem_addr_q.size() != 1)
      $display("FAIL coll_setup got valid=%0b inflight=%0d exp 1/1", imem_req_valid, mem_addr_q.size());
    else n_pass++;
    step(1'b1, 32'h0000_0300);
    wait_out("coll");
    n_checks++;
    if (out_pc !== 32'h0000_0300 || out_instr !== memf(32'h0000_0300))
      $display("FAIL coll_first got=%h/%h exp=00000300/%h", out_pc, out_instr, memf(32'h300));
    else n_pass++;
    repeat (10) step(1'b0, '0);
    $display("test_collision done: outs=%0d", n_out);
  endtask

  task automatic test_reset_midstream();
    do_reset();
    req_pct = 100; rsp_pct = 100; out_pct = 0;
    wait_out("rst_mid");
    sync_rst = 1'b1; redirect = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_pc, out_instr} !== 65'h0)
      $display("FAIL rst_mid_out got=%0b/%h/%h exp=0/0/0", out_valid, out_pc, out_instr);
    else n_pass++;
    sync_rst = 1'b0;
    model_clear();
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC)
      $display("FAIL rst_mid_req got=%0b/%h exp=1/%h", imem_req_valid, imem_req_addr, RESET_PC);
    else n_pass++;
    out_pct = 100;
    repeat (20) step(1'b0, '0);
    $display("test_reset_midstream done: outs=%0d", n_out);
  endtask

  task automatic test_misalign();
    do_reset();
    req_pct = 100; rsp_pct = 100; out_pct = 100;
    step(1'b0, '0);
    step(1'b1, 32'h0000_0102);
    wait_out("mis");
`ifdef FETCH_MISALIGN_EXC_EN
    n_checks++;
    if ({out_pc, out_instr, out_exc} !== {32'h0000_0102, 32'h0000_0013, 1'b1})
      $display("FAIL mis_entry got=%h/%h/%0b exp=00000102/00000013/1", out_pc, out_instr, out_exc);
    else n_pass++;
    repeat (6) step(1'b0, '0);
    n_checks++;
    if (imem_req_valid !== 1'b0) $display("FAIL mis_halted got=%0b exp=0", imem_req_valid);
    else n_pass++;
    step(1'b1, 32'h0000_0200);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0200)
      $display("FAIL mis_resume got=%0b/%h exp=1/00000200", imem_req_valid, imem_req_addr);
    else n_pass++;
`else
    n_checks++;
    if ({out_pc, out_exc} !== {32'h0000_0100, 1'b0})
      $display("FAIL mis_aligned got=%h/%0b exp=00000100/0", out_pc, out_exc);
    else n_pass++;
`endif
    repeat (10) step(1'b0, '0);
    $display("test_misalign done: outs=%0d", n_out);
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 0)   begin req_pct = 70; rsp_pct = 60; out_pct = 60; end
      if (i == 300) begin req_pct = 30; rsp_pct = 90; out_pct = 40; end
      if ($urandom_range(99) < 4) begin
        rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_0FFF);
        step(1'b1, rpc);
      end else begin
        step(1'b0, '0);
      end
    end
    n_checks++;
    if (n_out < 50) $display("FAIL random_progress got=%0d exp>=50", n_out);
    else n_pass++;
    $display("test_random done: reqs=%0d outs=%0d", n_req, n_out);
  endtask

  initial begin
    sync_rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; out_ready = 1'b0;
    req_pct = 100; rsp_pct = 100; out_pct = 100;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_collision();
    test_reset_midstream();
    test_misalign();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I pipelined core. Generates the PC stream, issues instruction-memory read requests, and pairs in-order responses with their PCs in a small allocation queue. Presents `{pc, instr}` with a valid/ready handshake directly to the IF/ID pipeline register. Handles control-flow redirects by discarding all queued and in-flight fetches.

## Interface

Parameters:
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `DEPTH`, default `2`: queue entries, and also the maximum number of in-flight requests. Power of two, ≥2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, all state on rising edge
- `sync_rst`  in  1  synchronous reset, active-high
- `redirect`  in  1  flush all fetches and restart at `redirect_pc`
- `redirect_pc`  in  32  new fetch address
- `imem_req_valid`  out  1  read request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  word address of request (bits [1:0] = 0)
- `imem_rsp_valid`  in  1  read data valid; always accepted, in request order
- `imem_rsp_data`  in  32  instruction word
- `out_valid`  out  1  entry valid toward IF/ID register
- `out_ready`  in  1  IF/ID register accepts
- `out_pc`  out  32  PC of presented instruction
- `out_instr`  out  32  instruction word
- `out_exc`  out  1  instruction-address-misaligned marker (see Configuration)

## Operation

- State:
  - `pc` register.
  - Circular queue of `DEPTH` entries `{pc, instr, filled, exc}`.
  - Pointers: `alloc_ptr`, `fill_ptr`, `head_ptr`.
  - `count`: allocated entries.
  - `drop_cnt`: stale responses still to be discarded. Width `$clog2(DEPTH)+1`.
  - `halted` flag.
- Issue:
  - `imem_req_valid = !halted && (count + drop_cnt < DEPTH)`.
  - `imem_req_addr = pc`.
  - On request handshake: allocate entry at `alloc_ptr` with `pc`, `filled=0`; then `pc += 4` (wraps modulo 2^32).
- Response:
  - If `drop_cnt != 0`: discard and decrement `drop_cnt`.
  - Otherwise: write `instr` into entry `fill_ptr`, set `filled=1`, advance `fill_ptr`.
- Output:
  - `out_valid = count != 0 && head.filled`. The `out_*` fields come from the head entry.
  - On `out_valid && out_ready`: free head, advance `head_ptr`.
- Redirect, asserted in any cycle:
  - Next state: `pc = redirect_pc & ~3`, queue emptied, pointers reset, `halted = 0`.
  - `drop_cnt = drop_cnt + (allocated-but-unfilled entries) + (request handshake this cycle) - (response this cycle, if counted)`.
  - Every pre-redirect request is dropped when it returns.
- Simultaneous events in the redirect cycle:
  - A response arriving that cycle is stale and is consumed; it is never written.
  - A request handshake that cycle is stale and is added to `drop_cnt`.
  - An output handshake that cycle completes normally. The downstream stage owns discarding it.
- Full: `count + drop_cnt == DEPTH` forces `imem_req_valid = 0`. A response and a request in the same cycle are both legal.
- Reset:
  - `pc = RESET_PC`, queue empty, `drop_cnt = 0`, `halted = 0`.
  - Reset overrides redirect. Responses to pre-reset requests are not tracked; the memory must also be reset.

## Timing

- Reset values, in the cycle after the reset edge: `out_valid = 0`, `out_pc = 0`, `out_instr = 0`, `out_exc = 0`.
- `imem_req_valid = 1` with `imem_req_addr = RESET_PC` in the first cycle after `sync_rst` deasserts.
- Throughput: one request per cycle while credits remain.
- Response to output: response in cycle N gives `out_valid` in cycle N+1 (registered queue). There is no combinational path from `imem_rsp_*` to `out_*`.
- Redirect to request: redirect in cycle N gives a request at `redirect_pc` in cycle N+1, if credits allow.
- `imem_req_valid` depends only on registered state. It does not depend on `imem_req_ready`, `redirect` or `out_ready`.
- `out_*` are stable while `out_valid && !out_ready`.

## Configuration

`FETCH_MISALIGN_EXC_EN`:
- Defined:
  - A redirect with `redirect_pc[1:0] != 0` issues no memory request.
  - Allocates one pre-filled entry `{pc=redirect_pc, instr=32'h0000_0013, exc=1}` and sets `halted = 1`.
  - The fetch unit stays halted until the next redirect or reset.
- Undefined:
  - `redirect_pc[1:0]` is ignored (forced to 0).
  - `out_exc` is tied to 0 and `halted` is never set.

## Test plan

- Reset, then memory with 1-cycle latency and `out_ready = 1` → requests at `0x0, 0x4, 0x8…` back-to-back; `out_pc`/`out_instr` pairs in order, first `out_valid` 2 cycles after the first request.
- `DEPTH = 2`, `out_ready = 0` → exactly 2 requests issued, then `imem_req_valid` held 0. Raising `out_ready` resumes issue one cycle later.
- Two requests in flight, `redirect` to `0x100` → both responses dropped (no `out_valid`); next delivered instruction has `out_pc = 0x100`.
- Redirect in the same cycle as a response and a request handshake → both stale; `drop_cnt` ends at 1; only post-redirect data reaches output.
- `sync_rst` asserted mid-stream with `out_valid = 1` → next cycle `out_valid = 0`, queue empty; restart fetching at `RESET_PC`.
- With `FETCH_MISALIGN_EXC_EN`, redirect to `0x102` → one output `{pc=0x102, exc=1}`, no imem request until a redirect to `0x200`, which resumes normal fetch.
